// File: rtl/io_trap_ctrl.sv
// io_trap_ctrl: traps Z80 I/O cycles to a configured port range, latches the access
// and raises a timed NMI, holding off further traps until the service routine acknowledges.
module io_trap_ctrl #(
    parameter int NMI_WIDTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_iorq_n,
    input  logic             i_m1_n,
    input  logic             i_rd_n,
    input  logic             i_wr_n,
    input  logic [7:0]       i_addr,
    input  logic [7:0]       i_data_in,
    input  logic             i_io_direction,
    input  logic [7:0]       i_trap_match,
    input  logic [7:0]       i_trap_mask,
    input  logic             i_trap_en,
    input  logic             i_svc_ack,
    output logic             o_nmi_n,
    output logic             o_trap_pending,
    output logic [7:0]       o_trap_port,
    output logic [7:0]       o_trap_data,
    output logic             o_trap_dir,
    output logic             o_dir_err,
    output logic [CNT_W-1:0] o_trap_count
);
    typedef enum logic [1:0] {IDLE, NMI, SERVICE} state_t;

    state_t           r_state;
    logic             r_cyc_prev;
    logic [3:0]       r_pulse;
    logic             r_nmi_n;
    logic             r_pending;
    logic [7:0]       r_port;
    logic [7:0]       r_data;
    logic             r_dir;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    logic w_cyc;
    logic w_start;
    logic w_hit;

    // Interrupt acknowledge (m1_n low) is excluded, so it can never look like an I/O cycle.
    assign w_cyc   = !i_iorq_n && i_m1_n && (!i_rd_n || !i_wr_n);
    assign w_start = w_cyc && !r_cyc_prev;
    assign w_hit   = ((i_addr ^ i_trap_match) & i_trap_mask) == 8'h00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cyc_prev <= 1'b0;
            r_pulse    <= 4'd0;
            r_nmi_n    <= 1'b1;
            r_pending  <= 1'b0;
            r_port     <= 8'h00;
            r_data     <= 8'h00;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_cyc_prev <= w_cyc;
            case (r_state)
                IDLE: begin
                    if (w_start && i_trap_en && w_hit && !i_svc_ack) begin
                        r_port    <= i_addr;
                        r_dir     <= i_io_direction;
                        r_data    <= !i_wr_n ? i_data_in : 8'h00;
                        r_err     <= i_io_direction == i_rd_n;
                        r_count   <= r_count + {{(CNT_W-1){1'b0}}, ~&r_count};
                        r_nmi_n   <= 1'b0;
                        r_pending <= 1'b1;
                        r_pulse   <= 4'(NMI_WIDTH - 1);
                        r_state   <= NMI;
                    end
                end
                NMI: begin
                    if (i_svc_ack) begin
                        r_nmi_n   <= 1'b1;
                        r_pending <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_pulse == 4'd0) begin
                        r_nmi_n <= 1'b1;
                        r_state <= SERVICE;
                    end else begin
                        r_pulse <= r_pulse - 4'd1;
                    end
                end
                SERVICE: begin
                    if (i_svc_ack) begin
                        r_pending <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_nmi_n        = r_nmi_n;
    assign o_trap_pending = r_pending;
    assign o_trap_port    = r_port;
    assign o_trap_data    = r_data;
    assign o_trap_dir     = r_dir;
    assign o_dir_err      = r_err;
    assign o_trap_count   = r_count;
endmodule

// File: doc/io_trap_ctrl.md
Name: io_trap_ctrl

Overview:
- Sequences the I/O virtualisation path of the Nabu MegaMapper CPLD.
- Watches Z80 I/O bus cycles and decides, using the opcode tracker's io_direction, whether an access to a trapped port range must be virtualised.
- On a trap: latches port, data and direction; fires a timed NMI; holds off further traps until the service routine acknowledges.
- Sits between the CPU bus decode, the opcode tracker and the NMI line.

Parameters:
- NMI_WIDTH, 4, cycles nmi_n is held low per trap (1..15).
- CNT_W, 8, width of the saturating trap counter.

Ports:
- clk  in  1  CPU clock (3.58 MHz); all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iorq_n  in  1  Z80 IORQ.
- m1_n  in  1  Z80 M1; iorq_n low with m1_n low is interrupt acknowledge, never trapped.
- rd_n  in  1  Z80 RD.
- wr_n  in  1  Z80 WR.
- addr  in  8  A[7:0] port address.
- data_in  in  8  CPU data bus.
- io_direction  in  1  from opcode tracker: 1 = IN, 0 = OUT.
- trap_match  in  8  port match value (config register).
- trap_mask  in  8  port mask; hit when (addr & trap_mask) == (trap_match & trap_mask).
- trap_en  in  1  global trap enable.
- svc_ack  in  1  one-cycle pulse from service-routine write to the control port.
- nmi_n  out  1  NMI request to CPU.
- trap_pending  out  1  high from capture until ack.
- trap_port  out  8  latched port.
- trap_data  out  8  latched OUT data; 8'h00 for IN.
- trap_dir  out  1  latched io_direction.
- dir_err  out  1  latched: io_direction disagreed with strobes.
- trap_count  out  CNT_W  saturating count of traps taken.

Behaviour:
- Reset values: nmi_n=1, trap_pending=0, trap_port=0, trap_data=0, trap_dir=0, dir_err=0, trap_count=0, state IDLE, pulse counter 0. Asserting rst_n mid-trap aborts immediately; nmi_n returns high asynchronously.
- I/O cycle start: rising edge where iorq_n=0, m1_n=1, (rd_n=0 or wr_n=0), and the previous sampled cycle had no such condition. Only one start event per bus cycle.
- IDLE: on a start event with trap_en=1 and port hit:
  - latch addr into trap_port and io_direction into trap_dir;
  - trap_data = data_in if wr_n=0, else 8'h00;
  - dir_err = (io_direction != !rd_n);
  - trap_count += 1, saturating at all-ones;
  - go to NMI.
  - Registers become visible 1 cycle after the start edge.
- NMI: nmi_n=0 for exactly NMI_WIDTH cycles, starting the cycle after capture, then go to SERVICE. trap_pending=1.
- SERVICE: nmi_n=1, trap_pending=1. Ignore all I/O starts; the service routine's own port accesses are never trapped. On svc_ack go to IDLE with trap_pending=0 on the next edge. Latched registers hold until the next capture.
- Acknowledge timing:
  - svc_ack during NMI is honoured. The pulse is truncated: nmi_n high next cycle, then go straight to IDLE.
  - svc_ack in IDLE is ignored.
- Simultaneous events:
  - An I/O start in the same cycle as svc_ack is not trapped.
  - trap_en dropping in NMI or SERVICE does not cancel the trap in progress.
- Interrupt acknowledge (m1_n=0, iorq_n=0) never produces a start event.
- Mask 8'h00 means every port hits.
- Counter saturates; it never wraps.

Test Plan:
- Reset, trap_en=1, match=8'h40, mask=8'hF0; OUT (0x42),0x5A (wr_n=0, io_direction=0) -> trap_port=0x42, trap_data=0x5A, trap_dir=0, dir_err=0, nmi_n low exactly 4 cycles, trap_pending=1, trap_count=1.
- In SERVICE, IN (0x41) (rd_n=0) -> no new capture, trap_port stays 0x42, count stays 1; then svc_ack -> trap_pending=0 next cycle.
- IN (0x30) with the same config -> no trap, nmi_n stays 1; INT acknowledge with addr=0x40 -> no trap.
- OUT to 0x45 with io_direction=1 (mismatch) -> dir_err=1, trap_data=0x45-cycle data; svc_ack on the 2nd NMI cycle -> nmi_n high the next cycle, state IDLE.
- CNT_W=8: 300 trap/ack pairs -> trap_count=8'hFF.
- Pull rst_n low on NMI cycle 2 -> nmi_n=1 immediately, all outputs at reset values; a subsequent trap behaves normally.
